// File: rtl/eth_pkg.sv
// Shared constants and FSM state encoding for the Ethernet FCS inserter.
// Lengths are sized to the 6-bit byte counter and 2-bit FCS index.
package eth_pkg;

  localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
  localparam logic [5:0]  MIN_FRAME_BYTES = 6'd60;
  localparam int          FCS_BYTES       = 4;
  localparam logic [1:0]  FCS_LAST_IDX    = 2'(FCS_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAD,
    FCS
  } state_e;

endpackage

// File: rtl/crc32_8bit.sv
// One-byte step of the reflected CRC-32 (poly 0xEDB88320), purely combinational.
// No state and no handshake; the caller decides when the result is registered.
module crc32_8bit (
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_byte,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY = 32'hEDB8_8320;

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h0, data_byte};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_fcs_inserter.sv
// Appends Ethernet FCS (optionally zero-padding to 60 bytes); zero-latency pass-through.
// Backpressure: in_ready follows out_ready while passing data, held low during pad/FCS.
module eth_fcs_inserter
  import eth_pkg::*;
#(
  parameter int PAD_TO_MIN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready
);

  state_e      state_q, state_d;
  logic [31:0] crc_q, crc_d, crc_next, fcs;
  logic [5:0]  cnt_q, cnt_d, cnt_inc;
  logic [1:0]  idx_q, idx_d;
  logic        out_hs;

  // The CRC always advances over the byte actually leaving the block, so pad bytes are covered.
  crc32_8bit u_crc (
    .crc_in    (crc_q),
    .data_byte (out_data),
    .crc_out   (crc_next)
  );

  assign fcs     = ~crc_q;
  assign cnt_inc = (cnt_q == MIN_FRAME_BYTES) ? cnt_q : cnt_q + 6'd1;
  assign out_hs  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      crc_q   <= CRC32_INIT;
      cnt_q   <= 6'd0;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_data  = 8'h00;
    out_valid = 1'b0;
    out_last  = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE, DATA: begin
          out_data  = in_data;
          out_valid = in_valid;
          in_ready  = out_ready;
        end
        PAD: begin
          out_valid = 1'b1;
        end
        FCS: begin
          out_valid = 1'b1;
          out_data  = fcs[8*idx_q +: 8];
          out_last  = (idx_q == FCS_LAST_IDX);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE, DATA: begin
        if (out_hs) begin
          crc_d   = crc_next;
          cnt_d   = cnt_inc;
          state_d = DATA;
          if (in_last) begin
            if ((PAD_TO_MIN != 0) && (cnt_inc < MIN_FRAME_BYTES)) begin
              state_d = PAD;
            end else begin
              state_d = FCS;
              idx_d   = 2'd0;
            end
          end
        end
      end
      PAD: begin
        if (out_hs) begin
          crc_d = crc_next;
          cnt_d = cnt_inc;
          if (cnt_inc == MIN_FRAME_BYTES) begin
            state_d = FCS;
            idx_d   = 2'd0;
          end
        end
      end
      FCS: begin
        if (out_hs) begin
          if (idx_q == FCS_LAST_IDX) begin
            state_d = IDLE;
            crc_d   = CRC32_INIT;
            cnt_d   = 6'd0;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
